// File: rtl/matrix_pkg.sv
// Shared types and constants for the scrolling matrix frame source.
package matrix_pkg;

  localparam int unsigned ROW_W = 16;
  localparam int unsigned COL_W = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  function automatic logic [ROW_W-1:0] blank(input logic active_low);
    return active_low ? '1 : '0;
  endfunction

endpackage

// File: rtl/msg_col_ram.sv
// Message column store: one synchronous write port, one registered read port.
module msg_col_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6,
  parameter int unsigned W     = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/matrix_scroll_source.sv
// Stores a loaded message and serves the row pattern for the scanner's column,
// advancing a wrapping 16-column window every SCROLL_DIV frames.
module matrix_scroll_source
  import matrix_pkg::*;
#(
  parameter int unsigned MSG_COLS   = 64,
  parameter int unsigned SCROLL_DIV = 256,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_start,
  input  logic                        wr_valid,
  input  logic [15:0]                 wr_data,
  input  logic                        wr_last,
  output logic                        wr_ready,
  input  logic                        run_en,
  input  logic                        frame_tick,
  input  logic [3:0]                  scan_col,
  output logic [15:0]                 col_data,
  output logic [$clog2(MSG_COLS)-1:0] scroll_pos,
  output logic                        scroll_wrap
);

  localparam int unsigned AW = $clog2(MSG_COLS);
  localparam int unsigned CW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   msg_len_q, msg_len_d;
  logic [AW-1:0] scroll_pos_q, scroll_pos_d;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
  logic          scroll_wrap_q, scroll_wrap_d;
  logic          blank_q, blank_d;

  logic          ram_we;
  logic [AW:0]   idx_raw, idx_wrap;
  logic [ROW_W-1:0] rd_data;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    msg_len_d     = msg_len_q;
    scroll_pos_d  = scroll_pos_q;
    frame_cnt_d   = frame_cnt_q;
    scroll_wrap_d = 1'b0;
    ram_we        = 1'b0;

    if (load_start) begin
      state_d  = LOAD;
      wr_ptr_d = '0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (wr_valid) begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (wr_last || (wr_ptr_q == AW'(MSG_COLS - 1))) begin
              msg_len_d    = {1'b0, wr_ptr_q} + (AW+1)'(1);
              scroll_pos_d = '0;
              frame_cnt_d  = '0;
              wr_ptr_d     = '0;
              state_d      = RUN;
            end
          end
        end
        RUN: begin
          if (frame_tick && run_en) begin
            if (frame_cnt_q == CW'(SCROLL_DIV - 1)) begin
              frame_cnt_d = '0;
              if ({1'b0, scroll_pos_q} == (msg_len_q - (AW+1)'(1))) begin
                scroll_pos_d  = '0;
                scroll_wrap_d = 1'b1;
              end else begin
                scroll_pos_d = scroll_pos_q + AW'(1);
              end
            end else begin
              frame_cnt_d = frame_cnt_q + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // A single conditional subtract suffices for messages of 16+ columns;
  // anything still out of range belongs to a short message and is blanked.
  always_comb begin
    idx_raw  = {1'b0, scroll_pos_q} + {{(AW+1-COL_W){1'b0}}, scan_col};
    idx_wrap = (idx_raw >= msg_len_q) ? (idx_raw - msg_len_q) : idx_raw;
    blank_d  = !((state_q == RUN) && !load_start && (idx_wrap < msg_len_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= EMPTY;
      wr_ptr_q      <= '0;
      msg_len_q     <= '0;
      scroll_pos_q  <= '0;
      frame_cnt_q   <= '0;
      scroll_wrap_q <= 1'b0;
      blank_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      msg_len_q     <= msg_len_d;
      scroll_pos_q  <= scroll_pos_d;
      frame_cnt_q   <= frame_cnt_d;
      scroll_wrap_q <= scroll_wrap_d;
      blank_q       <= blank_d;
    end
  end

  msg_col_ram #(
    .DEPTH (MSG_COLS),
    .AW    (AW),
    .W     (ROW_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (idx_wrap[AW-1:0]),
    .rdata (rd_data)
  );

  assign wr_ready    = (state_q == LOAD);
  assign scroll_pos  = scroll_pos_q;
  assign scroll_wrap = scroll_wrap_q;
  assign col_data    = blank_q    ? blank(ACTIVE_LOW) :
                       ACTIVE_LOW ? ~rd_data : rd_data;

endmodule

// File: tb/tb_matrix_scroll_source.sv
// Directed bench for matrix_scroll_source with hand-computed expectations.
module tb_matrix_scroll_source;

  logic        clk = 1'b0;
  logic        rst, load_start, wr_valid, wr_last, run_en, frame_tick;
  logic [15:0] wr_data;
  logic [3:0]  scan_col;
  logic        wr_ready, scroll_wrap;
  logic [15:0] col_data;
  logic [5:0]  scroll_pos;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  matrix_scroll_source #(
    .MSG_COLS   (64),
    .SCROLL_DIV (2),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_last     (wr_last),
    .wr_ready    (wr_ready),
    .run_en      (run_en),
    .frame_tick  (frame_tick),
    .scan_col    (scan_col),
    .col_data    (col_data),
    .scroll_pos  (scroll_pos),
    .scroll_wrap (scroll_wrap)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lit(input int v);
    logic [15:0] t;
    t = v[15:0];
    return ~t;
  endfunction

  task automatic write_beat(input logic [15:0] d, input logic last);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = last;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic pulse_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic look(input string tag, input logic [3:0] c, input logic [15:0] exp);
    scan_col = c;
    tick();
    chk(tag, col_data, exp);
  endtask

  initial begin
    int exp_pos;
    int fcnt;
    int wraps;

    rst = 1'b1; load_start = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
    wr_data = '0; run_en = 1'b1; frame_tick = 1'b0; scan_col = '0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_pos", scroll_pos, 0);
    chk("rst_wrap", scroll_wrap, 0);
    for (int s = 0; s < 16; s++) look("empty_sweep", 4'(s), 16'hFFFF);

    // 20-column message, data = column index
    pulse_load();
    chk("load_ready", wr_ready, 1);
    chk("load_blank", col_data, 16'hFFFF);
    for (int i = 0; i < 20; i++) write_beat(16'(i), i == 19);
    chk("run_ready", wr_ready, 0);
    chk("run_pos0", scroll_pos, 0);
    look("run_col5", 4'd5, lit(5));
    look("run_col0", 4'd0, lit(0));
    look("run_col15", 4'd15, lit(15));

    // Scroll with SCROLL_DIV=2 over 40 frames, scan column held at 15
    exp_pos = 0; fcnt = 0; wraps = 0;
    for (int k = 1; k <= 40; k++) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      if (scroll_wrap) wraps++;
      fcnt++;
      if (fcnt == 2) begin
        fcnt = 0;
        exp_pos = (exp_pos == 19) ? 0 : exp_pos + 1;
      end
      chk("scroll_pos", scroll_pos, exp_pos);
      tick();
      if (scroll_wrap) wraps++;
      chk("scroll_col15", col_data, lit((exp_pos + 15) % 20));
    end
    chk("wrap_count", wraps, 1);

    run_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      tick();
      chk("frozen_pos", scroll_pos, 0);
    end
    run_en = 1'b1;

    // 4-column message: columns 0-3 lit, 8-15 out of range
    pulse_load();
    for (int i = 0; i < 4; i++) write_beat(16'h1111 * 16'(i + 1), i == 3);
    for (int s = 0; s < 4; s++) look("short_data", 4'(s), lit(16'h1111 * (s + 1)));
    for (int s = 8; s < 16; s++) look("short_blank", 4'(s), 16'hFFFF);

    // load_start wins over a qualifying frame_tick
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    chk("pre_ls_pos", scroll_pos, 0);
    load_start = 1'b1; frame_tick = 1'b1;
    tick();
    load_start = 1'b0; frame_tick = 1'b0;
    chk("ls_pos", scroll_pos, 0);
    chk("ls_ready", wr_ready, 1);
    chk("ls_blank", col_data, 16'hFFFF);

    // Full buffer without wr_last
    for (int i = 0; i < 64; i++) write_beat(16'h0100 + 16'(i), 1'b0);
    chk("full_ready", wr_ready, 0);
    chk("full_pos", scroll_pos, 0);
    look("full_col0", 4'd0, lit(16'h0100));
    look("full_col15", 4'd15, lit(16'h010F));
    for (int k = 0; k < 126; k++) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      tick();
    end
    chk("full_pos63", scroll_pos, 63);
    look("full_wrap_idx", 4'd1, lit(16'h0100));
    look("full_last", 4'd0, lit(16'h013F));
    frame_tick = 1'b1;
    tick();
    chk("full_nowrap", scroll_wrap, 0);
    tick();
    frame_tick = 1'b0;
    chk("full_wrap", scroll_wrap, 1);
    chk("full_pos_wrap", scroll_pos, 0);
    tick();
    chk("full_wrap_end", scroll_wrap, 0);

    // Single-column message wraps on every step
    pulse_load();
    write_beat(16'h00F0, 1'b1);
    look("one_col0", 4'd0, lit(16'h00F0));
    look("one_col3", 4'd3, 16'hFFFF);
    for (int k = 0; k < 2; k++) begin
      frame_tick = 1'b1;
      tick();
      tick();
      frame_tick = 1'b0;
      chk("one_wrap", scroll_wrap, 1);
      chk("one_pos", scroll_pos, 0);
      tick();
    end

    // Reset in the middle of a load
    pulse_load();
    write_beat(16'hAAAA, 1'b0);
    write_beat(16'h5555, 1'b0);
    rst = 1'b1; wr_valid = 1'b1;
    tick();
    rst = 1'b0; wr_valid = 1'b0;
    chk("mid_rst_ready", wr_ready, 0);
    chk("mid_rst_blank", col_data, 16'hFFFF);
    chk("mid_rst_pos", scroll_pos, 0);
    chk("mid_rst_wrap", scroll_wrap, 0);
    frame_tick = 1'b1;
    tick(); tick();
    frame_tick = 1'b0;
    chk("empty_tick_pos", scroll_pos, 0);
    look("empty_blank", 4'd0, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
